uart_echo_buf: RTL and testbench
================================

Name: uart_echo_buf

Overview:
- Buffered echo controller between uart_rx and uart_tx in the UART loopback top.
- Captures every received frame into a parametrised FIFO and re-issues the frames to the transmitter, one handshake at a time.
- Lets back-to-back RX frames survive while TX is busy.
- Adds registered pattern-match LED toggle, overflow accounting and a TX-completion watchdog.

Parameters:
- DATA_W, 8: frame data width in bits.
- DEPTH, 16: FIFO entries; power of two, minimum 2.
- MATCH_BYTE, 8'h69: RX value that toggles led; width DATA_W.
- TIMEOUT_CYC, 100000: maximum cycles to wait for tx_done after send_en; must exceed one frame time at the slowest Baud_Set.
- CNT_W, 8: width of the drop counter.

Ports:
- sys_clk  in  1  system clock; the only clock.
- sys_rst_n  in  1  reset, asynchronous assert, active-low.
- rx_data  in  DATA_W  parallel data from uart_rx; valid when rx_done is high.
- rx_done  in  1  uart_rx frame-complete flag; may be high for one or more cycles.
- tx_busy  in  1  uart_tx busy.
- tx_done  in  1  uart_tx one-cycle frame-sent pulse.
- tx_data  out  DATA_W  data to uart_tx; held stable from load until tx_done or timeout.
- send_en  out  1  one-cycle transmit request to uart_tx.
- clr_flags  in  1  synchronous clear of ovf, tx_err and drop_cnt.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- ovf  out  1  sticky: a frame was dropped because the FIFO was full.
- tx_err  out  1  sticky: tx_done was not seen within TIMEOUT_CYC.
- drop_cnt  out  CNT_W  count of dropped frames; saturates at all-ones.
- led  out  1  registered; toggles on each received frame equal to MATCH_BYTE.

Behaviour:
- Reset values: all outputs 0; FIFO empty; FSM in IDLE; watchdog counter 0; rx_done edge register 0.
- Push:
  - Rising edge of rx_done is detected with a one-flop history: rx_done=1 and rx_done_q=0.
  - rx_data is written at that same clock edge.
  - A multi-cycle rx_done produces exactly one push.
- Full FIFO:
  - Push while full with no pop in the same cycle: frame dropped, ovf<=1, drop_cnt increments (saturating).
  - Push while full with a simultaneous pop: accepted, level unchanged.
- Simultaneous push and pop on a non-empty FIFO: level unchanged.
- Empty FIFO: never popped.
- LED:
  - led toggles on every detected rx_done rising edge where rx_data==MATCH_BYTE.
  - This includes frames that are dropped.
- FSM states IDLE, LOAD, SEND, WAIT:
  - IDLE -> LOAD when FIFO not empty and tx_busy=0.
  - LOAD: pop the FIFO head into tx_data; -> SEND.
  - SEND: send_en=1 for exactly this one cycle; clear watchdog; -> WAIT.
  - WAIT -> IDLE on tx_done=1.
  - WAIT -> IDLE with tx_err<=1 when the watchdog reaches TIMEOUT_CYC-1; that frame is considered lost.
- send_en is decoded from state==SEND and is glitch-free (state register is one-hot or binary registered).
- Latency: a push at edge E0 into an empty FIFO with TX idle gives send_en high in the cycle after edge E2.
- Sustained throughput: one frame per TX frame time plus 3 cycles.
- tx_done outside WAIT is ignored.
- clr_flags:
  - Clears ovf, tx_err and drop_cnt at the next edge.
  - Has priority over a same-cycle set, except that a same-cycle overflow still sets ovf=1 and drop_cnt=1.
- Reset mid-operation: FIFO flushed, FSM to IDLE, send_en deasserted immediately (asynchronous).
- fifo_level is registered and reflects pushes/pops of the previous edge.

Decomposition:
- Package uart_pkg: FSM state enum (IDLE/LOAD/SEND/WAIT), default MATCH_BYTE, default TIMEOUT_CYC, Baud_Set encodings shared with uart_tx/uart_rx.
- Sub-module sync_fifo (DATA_W, DEPTH):
  - Registered level, full/empty flags.
  - Push/pop inputs, with push-when-full accepted only when pop is asserted.
  - Holds all storage.
- Edge detect, FSM, watchdog, flags and LED live in uart_echo_buf.

Test Plan:
- Single frame 8'hA5, rx_done held 4 cycles, tx_busy=0 -> exactly one push; send_en one cycle at E0+3 edge with tx_data=8'hA5; fifo_level returns to 0.
- 5 frames 01..05 pushed while tx_busy=1 -> fifo_level=5; after release, tx_data sequence 01,02,03,04,05 with one send_en each, gated by tx_done.
- DEPTH=16, 20 frames pushed with TX stalled -> fifo_level=16, ovf=1, drop_cnt=4; frames 1..16 echoed in order; clr_flags -> ovf=0, drop_cnt=0.
- Push on the same edge as a LOAD pop with FIFO full -> no drop, ovf stays 0, level stays 16.
- Frames 69,00,69,69 -> led sequence 1,1,0,1.
- TIMEOUT_CYC=50, tx_done never pulses -> tx_err=1 at send_en+50 cycles; FSM returns to IDLE and the next frame is issued; sys_rst_n pulsed low mid-WAIT -> all outputs 0 and FIFO empty.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART loopback definitions: echo FSM states, echo defaults and Baud_Set codes.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_WAIT = 2'd3
  } echo_state_t;

  localparam logic [7:0] DEF_MATCH_BYTE  = 8'h69;
  localparam int         DEF_TIMEOUT_CYC = 100000;

  // Baud_Set encodings understood by uart_tx / uart_rx
  localparam logic [2:0] BAUD_SET_9600   = 3'd0;
  localparam logic [2:0] BAUD_SET_19200  = 3'd1;
  localparam logic [2:0] BAUD_SET_38400  = 3'd2;
  localparam logic [2:0] BAUD_SET_57600  = 3'd3;
  localparam logic [2:0] BAUD_SET_115200 = 3'd4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; a push while full is taken only
// when a pop frees the head slot on the same edge.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset; pointers and level define what is valid.
  always_ff @(posedge sys_clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_echo_buf.sv
// Buffered RX->TX echo with match LED, overflow accounting and TX watchdog.
//   state | meaning
//   IDLE  | wait for a queued frame and an idle transmitter
//   LOAD  | pop FIFO head into tx_data
//   SEND  | one-cycle send_en, arm watchdog
//   WAIT  | wait for tx_done or watchdog expiry
module uart_echo_buf
  import uart_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter int                DEPTH       = 16,
  parameter logic [DATA_W-1:0] MATCH_BYTE  = DATA_W'(DEF_MATCH_BYTE),
  parameter int                TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int                CNT_W       = 8
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic [DATA_W-1:0]      rx_data,
  input  logic                   rx_done,
  input  logic                   tx_busy,
  input  logic                   tx_done,
  output logic [DATA_W-1:0]      tx_data,
  output logic                   send_en,
  input  logic                   clr_flags,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   ovf,
  output logic                   tx_err,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic                   led
);

  localparam int              WD_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYC - 1);

  echo_state_t       state;
  echo_state_t       state_nxt;
  logic              rx_done_q;
  logic              push;
  logic              pop;
  logic              drop;
  logic              timeout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rd;
  logic [WD_W-1:0]   wd_cnt;

  assign push    = rx_done && !rx_done_q;
  assign pop     = (state == ST_LOAD);
  assign drop    = push && fifo_full && !pop;
  assign timeout = (state == ST_WAIT) && !tx_done && (wd_cnt == '0);
  assign send_en = (state == ST_SEND);

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .push      (push),
    .pop       (pop),
    .wr_data   (rx_data),
    .rd_data   (fifo_rd),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ST_IDLE;
      rx_done_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      rx_done_q <= rx_done;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (!fifo_empty && !tx_busy) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_SEND;
      ST_SEND: state_nxt = ST_WAIT;
      ST_WAIT: if (tx_done || wd_cnt == '0) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Down-counter armed in SEND; reaching zero marks TIMEOUT_CYC cycles of WAIT.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wd_cnt  <= '0;
      tx_data <= '0;
    end else begin
      if (state == ST_SEND)                        wd_cnt <= WD_LOAD;
      else if (state == ST_WAIT && wd_cnt != '0)   wd_cnt <= wd_cnt - 1'b1;
      if (state == ST_LOAD) tx_data <= fifo_rd;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ovf      <= 1'b0;
      tx_err   <= 1'b0;
      drop_cnt <= '0;
      led      <= 1'b0;
    end else begin
      if (clr_flags) begin
        // A drop on the clearing edge is still recorded as the first new event.
        ovf      <= drop;
        drop_cnt <= drop ? CNT_W'(1) : '0;
        tx_err   <= 1'b0;
      end else begin
        if (drop) ovf <= 1'b1;
        if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        if (timeout) tx_err <= 1'b1;
      end
      if (push && rx_data == MATCH_BYTE) led <= ~led;
    end
  end

endmodule

// File: tb/tb_uart_echo_buf.sv
// Directed, table-driven bench for uart_echo_buf (DEPTH=16, TIMEOUT_CYC=50).
module tb_uart_echo_buf;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       tx_busy;
  logic       tx_done;
  logic [7:0] tx_data;
  logic       send_en;
  logic       clr_flags;
  logic [4:0] fifo_level;
  logic       ovf;
  logic       tx_err;
  logic [7:0] drop_cnt;
  logic       led;

  int checks = 0;
  int errors = 0;

  uart_echo_buf #(
    .DATA_W      (8),
    .DEPTH       (16),
    .MATCH_BYTE  (8'h69),
    .TIMEOUT_CYC (50),
    .CNT_W       (8)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_data    (tx_data),
    .send_en    (send_en),
    .clr_flags  (clr_flags),
    .fifo_level (fifo_level),
    .ovf        (ovf),
    .tx_err     (tx_err),
    .drop_cnt   (drop_cnt),
    .led        (led)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [7:0] data;
    int         hold;
    int         level;
    logic       ovf;
    int         drop;
    logic       led;
  } vec_t;

  vec_t vecs[20];

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] d, input int hold);
    rx_data = d;
    rx_done = 1'b1;
    repeat (hold) tick();
    rx_done = 1'b0;
    tick();
  endtask

  task automatic wait_send(input logic [7:0] exp);
    int n = 0;
    while (!send_en && n < 40) begin
      tick();
      n++;
    end
    check("send_en_seen", 32'(send_en), 32'd1);
    if (send_en) check("tx_data", 32'(tx_data), 32'(exp));
  endtask

  task automatic echo_one(input logic [7:0] exp);
    logic extra = 1'b0;
    wait_send(exp);
    repeat (3) begin
      tick();
      extra |= send_en;
    end
    check("send_en_single", 32'(extra), 32'd0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_send_en"},  32'(send_en),    32'd0);
    check({tag, "_tx_data"},  32'(tx_data),    32'd0);
    check({tag, "_level"},    32'(fifo_level), 32'd0);
    check({tag, "_ovf"},      32'(ovf),        32'd0);
    check({tag, "_tx_err"},   32'(tx_err),     32'd0);
    check({tag, "_drop_cnt"}, 32'(drop_cnt),   32'd0);
    check({tag, "_led"},      32'(led),        32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic seen;

    vecs[0]  = '{8'h69, 1, 1,  1'b0, 0, 1'b1};
    vecs[1]  = '{8'h00, 3, 2,  1'b0, 0, 1'b1};
    vecs[2]  = '{8'h69, 1, 3,  1'b0, 0, 1'b0};
    vecs[3]  = '{8'h69, 2, 4,  1'b0, 0, 1'b1};
    for (int i = 4; i < 16; i++) vecs[i] = '{8'(i - 3), 1 + (i % 3), i + 1, 1'b0, 0, 1'b1};
    vecs[16] = '{8'hE0, 1, 16, 1'b1, 1, 1'b1};
    vecs[17] = '{8'h69, 2, 16, 1'b1, 2, 1'b0};
    vecs[18] = '{8'hE2, 1, 16, 1'b1, 3, 1'b0};
    vecs[19] = '{8'hE3, 4, 16, 1'b1, 4, 1'b0};

    sys_rst_n = 1'b0;
    rx_data   = 8'h00;
    rx_done   = 1'b0;
    tx_busy   = 1'b0;
    tx_done   = 1'b0;
    clr_flags = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    sys_rst_n = 1'b1;
    tick();

    // Single frame, rx_done held four cycles
    rx_data = 8'hA5;
    rx_done = 1'b1;
    tick();
    check("single_level_e0", 32'(fifo_level), 32'd1);
    tick();
    check("single_send_e1", 32'(send_en), 32'd0);
    tick();
    check("single_send_e2", 32'(send_en), 32'd1);
    check("single_tx_data", 32'(tx_data), 32'hA5);
    check("single_level_e2", 32'(fifo_level), 32'd0);
    tick();
    check("single_send_e3", 32'(send_en), 32'd0);
    rx_done = 1'b0;
    tick();
    check("single_one_push", 32'(fifo_level), 32'd0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen |= send_en;
    end
    check("single_no_resend", 32'(seen), 32'd0);

    // Fill with TX stalled: led pattern, full boundary, drops
    tx_busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      push_frame(vecs[i].data, vecs[i].hold);
      check($sformatf("vec%0d_level", i), 32'(fifo_level), 32'(vecs[i].level));
      check($sformatf("vec%0d_ovf", i),   32'(ovf),        32'(vecs[i].ovf));
      check($sformatf("vec%0d_drop", i),  32'(drop_cnt),   32'(vecs[i].drop));
      check($sformatf("vec%0d_led", i),   32'(led),        32'(vecs[i].led));
    end

    // clr_flags on the same edge as a drop
    rx_data   = 8'hE4;
    rx_done   = 1'b1;
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    rx_done   = 1'b0;
    tick();
    check("clr_drop_ovf",  32'(ovf),      32'd1);
    check("clr_drop_cnt",  32'(drop_cnt), 32'd1);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("clr_ovf",    32'(ovf),      32'd0);
    check("clr_cnt",    32'(drop_cnt), 32'd0);
    check("clr_tx_err", 32'(tx_err),   32'd0);

    // Drop counter saturation
    for (int i = 0; i < 260; i++) push_frame(8'hE5, 1);
    check("sat_drop_cnt", 32'(drop_cnt),   32'hFF);
    check("sat_ovf",      32'(ovf),        32'd1);
    check("sat_level",    32'(fifo_level), 32'd16);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("sat_clr_cnt", 32'(drop_cnt), 32'd0);
    check("sat_clr_ovf", 32'(ovf),      32'd0);

    // Push on the same edge as the LOAD pop while full
    tx_busy = 1'b0;
    tick();
    rx_data = 8'hF0;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    check("simul_level",   32'(fifo_level), 32'd16);
    check("simul_ovf",     32'(ovf),        32'd0);
    check("simul_drop",    32'(drop_cnt),   32'd0);
    check("simul_send_en", 32'(send_en),    32'd1);
    echo_one(8'h69);
    echo_one(8'h00);
    echo_one(8'h69);
    echo_one(8'h69);
    for (int i = 1; i <= 12; i++) echo_one(8'(i));
    echo_one(8'hF0);
    check("drain_level", 32'(fifo_level), 32'd0);

    // Five frames queued behind a busy transmitter
    tx_busy = 1'b1;
    for (int i = 1; i <= 5; i++) push_frame(8'(i), 1);
    check("five_level", 32'(fifo_level), 32'd5);
    seen = 1'b0;
    repeat (4) begin
      tick();
      seen |= send_en;
    end
    check("five_busy_hold", 32'(seen), 32'd0);
    tx_busy = 1'b0;
    for (int i = 1; i <= 5; i++) echo_one(8'(i));
    check("five_drain_level", 32'(fifo_level), 32'd0);

    // Watchdog: tx_done never arrives
    tx_busy = 1'b1;
    push_frame(8'h3C, 1);
    push_frame(8'h3D, 1);
    push_frame(8'h3E, 1);
    tx_busy = 1'b0;
    wait_send(8'h3C);
    repeat (50) tick();
    check("wd_not_yet", 32'(tx_err), 32'd0);
    tick();
    check("wd_tx_err", 32'(tx_err), 32'd1);
    wait_send(8'h3D);
    check("wd_level", 32'(fifo_level), 32'd1);

    // Asynchronous reset while send_en is high
    sys_rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    repeat (2) tick();
    sys_rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      tick();
      seen |= send_en;
    end
    check("post_rst_no_send", 32'(seen),       32'd0);
    check("post_rst_level",   32'(fifo_level), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
